// File: rtl/s_box_pipelined_if.sv
// s_box_pipelined_if: beat handshake bundle for s_box_pipelined.
// master drives beats in and accepts results; slave is the S-box pipeline.
interface s_box_pipelined_if #(
    parameter int XLEN  = 8,
    parameter int LANES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic [LANES*XLEN-1:0] in;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_mode;
    logic [LANES*XLEN-1:0] out;
    logic                  busy;
    modport master (
        output in_valid, in_mode, in, out_ready,
        input  in_ready, out_valid, out_mode, out, busy
    );
    modport slave (
        input  in_valid, in_mode, in, out_ready,
        output in_ready, out_valid, out_mode, out, busy
    );
endinterface

// File: rtl/s_box_pipelined.sv
// s_box_pipelined: 3-stage AES S-box over GF((2^4)^2), LANES bytes per beat.
// Inverse S-box (in_mode=1) exists only when SBOX_INV_EN is defined.
module s_box_pipelined #(
    parameter int XLEN  = 8,
    parameter int LANES = 4
) (
    input logic              clk,
    input logic              rst,
    s_box_pipelined_if.slave bus
);
    localparam int W = LANES * XLEN;

    if (XLEN != 8) begin : g_bad_xlen
        $error("s_box_pipelined: XLEN must be 8");
    end
    if (LANES < 1 || LANES > 16) begin : g_bad_lanes
        $error("s_box_pipelined: LANES must be 1..16");
    end

    typedef logic [7:0][7:0] mat_t;

    function automatic logic [3:0] mul4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r, s;
        r = '0;
        s = a;
        for (int i = 0; i < 4; i++) begin
            r = b[i] ? r ^ s : r;
            s = {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0);
        end
        return r;
    endfunction

    // Composite element {h,l} = h*y + l with y^2 = y + lam.
    function automatic logic [7:0] mulc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] lam);
        logic [3:0] hh;
        hh = mul4(a[7:4], b[7:4]);
        return {hh ^ mul4(a[7:4], b[3:0]) ^ mul4(a[3:0], b[7:4]), mul4(a[3:0], b[3:0]) ^ mul4(lam, hh)};
    endfunction

    function automatic logic [3:0] find_lambda();
        logic [3:0] lam;
        logic       hit;
        lam = '0;
        for (int c = 15; c > 0; c--) begin
            hit = 1'b0;
            for (int z = 0; z < 16; z++)
                hit = hit | ((mul4(4'(z), 4'(z)) ^ 4'(z)) == 4'(c));
            lam = hit ? lam : 4'(c);
        end
        return lam;
    endfunction

    // A root of the AES polynomial inside the composite field fixes the isomorphism.
    function automatic logic [7:0] find_beta(input logic [3:0] lam);
        logic [7:0] r, x, x2, x4, x8;
        r = '0;
        for (int c = 255; c > 1; c--) begin
            x  = 8'(c);
            x2 = mulc(x, x, lam);
            x4 = mulc(x2, x2, lam);
            x8 = mulc(x4, x4, lam);
            r  = ((x8 ^ x4 ^ mulc(x2, x, lam) ^ x ^ 8'h01) == 8'h00) ? x : r;
        end
        return r;
    endfunction

    function automatic logic [7:0] apply(input mat_t m, input logic [7:0] a);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            r = a[i] ? r ^ m[i] : r;
        return r;
    endfunction

    function automatic mat_t iso_cols(input logic [3:0] lam, input logic [7:0] beta);
        mat_t m;
        m[0] = 8'h01;
        for (int i = 1; i < 8; i++)
            m[i] = mulc(m[i-1], beta, lam);
        return m;
    endfunction

    function automatic mat_t inv_cols(input mat_t iso);
        mat_t       m;
        logic [7:0] v;
        m = '0;
        for (int a = 0; a < 256; a++) begin
            v = apply(iso, 8'(a));
            for (int j = 0; j < 8; j++)
                m[j] = (v == 8'(1 << j)) ? 8'(a) : m[j];
        end
        return m;
    endfunction

    localparam logic [3:0] LAMBDA  = find_lambda();
    localparam logic [7:0] BETA    = find_beta(LAMBDA);
    localparam mat_t       ISO     = iso_cols(LAMBDA, BETA);
    localparam mat_t       ISO_INV = inv_cols(ISO);

    function automatic logic [3:0] inv4(input logic [3:0] a);
        logic [3:0] a3, a7;
        a3 = mul4(mul4(a, a), a);
        a7 = mul4(mul4(a3, a3), a);
        return mul4(a7, a7);
    endfunction

    function automatic logic [7:0] invc(input logic [7:0] c);
        logic [3:0] di;
        di = inv4(mul4(mul4(c[7:4], c[7:4]), LAMBDA) ^ mul4(c[7:4], c[3:0]) ^ mul4(c[3:0], c[3:0]));
        return {mul4(c[7:4], di), mul4(c[7:4] ^ c[3:0], di)};
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int k);
        logic [15:0] w;
        w = {b, b} << k;
        return w[15:8];
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
    endfunction

`ifdef SBOX_INV_EN
    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return rl(s, 1) ^ rl(s, 3) ^ rl(s, 6) ^ 8'h05;
    endfunction

    logic m1, m2, m3;
`endif

    logic         v1, v2, v3;
    logic [W-1:0] d1, d2, d3;
    logic [W-1:0] f1, f2, f3;
    logic         ld1, ld2, ld3;

    assign ld3          = !v3 || bus.out_ready;
    assign ld2          = !v2 || ld3;
    assign ld1          = !v1 || ld2;
    assign bus.in_ready = ld1;
    assign bus.out_valid = v3;
    assign bus.out       = d3;
    assign bus.busy      = v1 || v2 || v3;
`ifdef SBOX_INV_EN
    assign bus.out_mode  = m3;
`else
    assign bus.out_mode  = 1'b0;
`endif

    always_comb begin
        f1 = '0;
        f2 = '0;
        f3 = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef SBOX_INV_EN
            f1[i*8 +: 8] = apply(ISO, bus.in_mode ? inv_affine(bus.in[i*8 +: 8]) : bus.in[i*8 +: 8]);
            f3[i*8 +: 8] = m2 ? apply(ISO_INV, d2[i*8 +: 8]) : affine(apply(ISO_INV, d2[i*8 +: 8]));
`else
            f1[i*8 +: 8] = apply(ISO, bus.in[i*8 +: 8]);
            f3[i*8 +: 8] = affine(apply(ISO_INV, d2[i*8 +: 8]));
`endif
            f2[i*8 +: 8] = invc(d1[i*8 +: 8]);
        end
    end

    // Data registers only load real beats, so bubbles never disturb out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
`ifdef SBOX_INV_EN
            m1 <= 1'b0;
            m2 <= 1'b0;
            m3 <= 1'b0;
`endif
        end else begin
            if (ld1) v1 <= bus.in_valid;
            if (ld2) v2 <= v1;
            if (ld3) v3 <= v2;
            if (ld1 && bus.in_valid) d1 <= f1;
            if (ld2 && v1) d2 <= f2;
            if (ld3 && v2) d3 <= f3;
`ifdef SBOX_INV_EN
            if (ld1 && bus.in_valid) m1 <= bus.in_mode;
            if (ld2 && v1) m2 <= m1;
            if (ld3 && v2) m3 <= m2;
`endif
        end
    end
endmodule
